// File: rtl/usb_ls_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usb_ls_pkg
//  Purpose  : Shared line-state encodings, FSM states and constants for the
//             low-speed USB receiver.
//  Revision : 1.0  initial release
// ============================================================================
package usb_ls_pkg;

    // Line state is {dp, dm} after synchronization.
    localparam logic [1:0] c_SE0 = 2'b00;
    localparam logic [1:0] c_J   = 2'b01;
    localparam logic [1:0] c_K   = 2'b10;
    localparam logic [1:0] c_SE1 = 2'b11;

    localparam int OVERSAMPLE  = 8;
    localparam int STUFF_LIMIT = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_EOP   = 3'd3,
        ST_ABORT = 3'd4
    } rx_state_t;

    // True only for a differential J<->K change; SE0/SE1 edges do not count.
    function automatic logic is_jk_change(input logic [1:0] a, input logic [1:0] b);
        return ((a == c_J) && (b == c_K)) || ((a == c_K) && (b == c_J));
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_ls_dpll.sv
`default_nettype none
// ============================================================================
//  Module   : usb_ls_dpll
//  Purpose  : dp/dm synchronizer, edge-aligned phase counter and one-per-bit
//             sample strobe for 8x oversampled low-speed USB.
//  Revision : 1.0  initial release
// ============================================================================
module usb_ls_dpll
    import usb_ls_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_pll_lock,
    input  logic       i_dp,
    input  logic       i_dm,
    output logic [1:0] o_line_state,
    output logic       o_sample_en,
    output logic       o_j_to_k
);

    localparam int                c_PW        = $clog2(OVERSAMPLE);
    localparam logic [c_PW-1:0]   c_SAMPLE_AT = c_PW'(SAMPLE_PHASE);
    localparam logic [c_PW-1:0]   c_PH_ONE    = c_PW'(1);

    logic [SYNC_STAGES-1:0] r_dp_sync;
    logic [SYNC_STAGES-1:0] r_dm_sync;
    logic [1:0]             r_prev_ls;
    logic [c_PW-1:0]        r_phase;
    logic [1:0]             w_ls;
    logic                   w_jk_change;

    // The synchronizer keeps running regardless of pll_lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dp_sync <= '0;
            r_dm_sync <= '1;
        end else begin
            r_dp_sync[0] <= i_dp;
            r_dm_sync[0] <= i_dm;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_dp_sync[i] <= r_dp_sync[i-1];
                r_dm_sync[i] <= r_dm_sync[i-1];
            end
        end
    end

    assign w_ls        = {r_dp_sync[SYNC_STAGES-1], r_dm_sync[SYNC_STAGES-1]};
    assign w_jk_change = is_jk_change(r_prev_ls, w_ls);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_ls <= c_J;
            r_phase   <= '0;
        end else begin
            r_prev_ls <= w_ls;
            if (!i_pll_lock || w_jk_change) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + c_PH_ONE;
            end
        end
    end

    assign o_line_state = w_ls;
    assign o_sample_en  = i_pll_lock && (r_phase == c_SAMPLE_AT);
    assign o_j_to_k     = (r_prev_ls == c_J) && (w_ls == c_K);

endmodule
`default_nettype wire

// File: rtl/usb_ls_rx.sv
`default_nettype none
// ============================================================================
//  Module   : usb_ls_rx
//  Purpose  : Low-speed USB receiver: SYNC detect, NRZI decode, bit unstuffing,
//             byte assembly and EOP/error reporting.
//  Revision : 1.0  initial release
// ============================================================================
module usb_ls_rx
    import usb_ls_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       dp,
    input  logic       dm,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_err
);

    localparam logic [2:0] c_STUFF_LIM = 3'(STUFF_LIMIT);
    localparam logic [2:0] c_LAST_BIT  = 3'd7;
    localparam logic [2:0] c_ONE       = 3'd1;

    logic [1:0] w_ls;
    logic       w_sample;
    logic       w_j_to_k;
    logic       w_bit;
    logic [7:0] w_shift_next;

    rx_state_t  r_state;
    logic [1:0] r_prev_smp;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_ones;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_active;
    logic       r_valid;
    logic       r_eop;
    logic       r_err;

    usb_ls_dpll #(
        .SYNC_STAGES  (SYNC_STAGES),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) u_dpll (
        .clk          (clk),
        .reset        (reset),
        .i_pll_lock   (pll_lock),
        .i_dp         (dp),
        .i_dm         (dm),
        .o_line_state (w_ls),
        .o_sample_en  (w_sample),
        .o_j_to_k     (w_j_to_k)
    );

    // NRZI: an unchanged level decodes as 1.
    assign w_bit        = (w_ls == r_prev_smp);
    assign w_shift_next = {w_bit, r_shift[7:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_prev_smp <= c_J;
            r_bit_cnt  <= '0;
            r_ones     <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_active   <= 1'b0;
            r_valid    <= 1'b0;
            r_eop      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_eop   <= 1'b0;
            r_err   <= 1'b0;
            if (!pll_lock) begin
                r_state    <= ST_IDLE;
                r_active   <= 1'b0;
                r_bit_cnt  <= '0;
                r_ones     <= '0;
                r_prev_smp <= c_J;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_j_to_k) begin
                            r_state    <= ST_SYNC;
                            r_bit_cnt  <= '0;
                            r_prev_smp <= c_J;
                        end
                    end

                    ST_SYNC: begin
                        if (w_sample) begin
                            r_prev_smp <= w_ls;
                            if (w_ls == c_SE0) begin
                                r_state <= ST_IDLE;
                            end else if (w_ls == c_SE1) begin
                                r_err   <= 1'b1;
                                r_state <= ST_ABORT;
                            end else if ((w_ls == c_K) && (r_prev_smp == c_K)) begin
                                r_state   <= ST_DATA;
                                r_active  <= 1'b1;
                                r_bit_cnt <= '0;
                                r_ones    <= '0;
                            end else if (r_bit_cnt == c_LAST_BIT) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_ONE;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (w_sample) begin
                            r_prev_smp <= w_ls;
                            if (w_ls == c_SE0) begin
                                r_state <= ST_EOP;
                                if (r_bit_cnt != '0) begin
                                    r_err <= 1'b1;
                                end
                            end else if (w_ls == c_SE1) begin
                                r_err    <= 1'b1;
                                r_active <= 1'b0;
                                r_state  <= ST_ABORT;
                            end else if (r_ones == c_STUFF_LIM) begin
                                // Bit after six ones must be a stuffed 0.
                                if (w_bit) begin
                                    r_err    <= 1'b1;
                                    r_active <= 1'b0;
                                    r_state  <= ST_ABORT;
                                end else begin
                                    r_ones <= '0;
                                end
                            end else begin
                                r_shift <= w_shift_next;
                                r_ones  <= w_bit ? (r_ones + c_ONE) : '0;
                                if (r_bit_cnt == c_LAST_BIT) begin
                                    r_data    <= w_shift_next;
                                    r_valid   <= 1'b1;
                                    r_bit_cnt <= '0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + c_ONE;
                                end
                            end
                        end
                    end

                    ST_EOP: begin
                        if (w_sample) begin
                            r_prev_smp <= w_ls;
                            if (w_ls == c_J) begin
                                r_eop    <= 1'b1;
                                r_active <= 1'b0;
                                r_state  <= ST_IDLE;
                            end else if (w_ls != c_SE0) begin
                                r_err    <= 1'b1;
                                r_active <= 1'b0;
                                r_state  <= ST_ABORT;
                            end
                        end
                    end

                    ST_ABORT: begin
                        r_active <= 1'b0;
                        if (w_sample) begin
                            r_prev_smp <= w_ls;
                            if ((w_ls == c_J) && (r_prev_smp == c_SE0)) begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end

                    default: begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign line_state = w_ls;
    assign rx_active  = r_active;
    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign rx_eop     = r_eop;
    assign rx_err     = r_err;

endmodule
`default_nettype wire
